// File: rtl/bus_1553_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_1553_pkg
// Purpose  : Shared constants for the MIL-STD-1553 dual-redundant A/B switch.
// Revision : 1.0 - initial release
// ============================================================================
package bus_1553_pkg;

    localparam int SYNC_STAGES = 2;

    localparam logic BUS_A = 1'b0;
    localparam logic BUS_B = 1'b1;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_TX      = 2'd1;
    localparam logic [1:0] ST_TX_TAIL = 2'd2;
    localparam logic [1:0] ST_RX      = 2'd3;

endpackage
`default_nettype wire

// File: rtl/activity_det_1553.sv
`default_nettype none
// ============================================================================
// Module   : activity_det_1553
// Purpose  : Receiver synchroniser plus idle counter; busy while the bus has
//            changed within the last IDLE_CYC cycles.
// Revision : 1.0 - initial release
// ============================================================================
module activity_det_1553 #(
    parameter int IDLE_CYC = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_diff,
    output logic [1:0] o_sync_diff,
    output logic       o_busy
);
    import bus_1553_pkg::*;

    localparam int c_cnt_w = $clog2(IDLE_CYC + 1);
    localparam logic [c_cnt_w-1:0] c_reload = c_cnt_w'(IDLE_CYC);

    logic [1:0]         r_sync [SYNC_STAGES];
    logic [1:0]         r_prev;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_change;

    assign o_sync_diff = r_sync[SYNC_STAGES-1];
    assign w_change    = (r_sync[SYNC_STAGES-1] != r_prev);
    assign o_busy      = (r_cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= 2'b00;
            r_prev <= 2'b00;
            r_cnt  <= '0;
        end else begin
            r_sync[0] <= i_diff;
            for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
            r_prev <= r_sync[SYNC_STAGES-1];
            // Any edge on the pair restarts the quiet window; otherwise count down and hold at zero.
            if (w_change)
                r_cnt <= c_reload;
            else if (r_cnt != '0)
                r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_ab_switch_1553.sv
`default_nettype none
// ============================================================================
// Module   : bus_ab_switch_1553
// Purpose  : Dual-redundant 1553 bus A/B switch with activity-following bus
//            selection and transceiver echo (loopback) checking.
// Revision : 1.0 - initial release
// ============================================================================
module bus_ab_switch_1553 #(
    parameter int CLOCK_SPEED    = 100000000,
    parameter int IDLE_US        = 2,
    parameter int LOOP_DELAY     = 0,
    parameter int MISMATCH_LIMIT = 8
) (
    input  logic       aclk,
    input  logic       arst,
    input  logic [1:0] core_o_diff,
    input  logic       core_en_o_diff,
    output logic [1:0] core_i_diff,
    input  logic [1:0] bus_a_i_diff,
    output logic [1:0] bus_a_o_diff,
    output logic       bus_a_en_o_diff,
    input  logic [1:0] bus_b_i_diff,
    output logic [1:0] bus_b_o_diff,
    output logic       bus_b_en_o_diff,
    input  logic       bus_sel,
    input  logic       auto_switch,
    input  logic       err_clr,
    output logic       active_bus,
    output logic       bus_a_busy,
    output logic       bus_b_busy,
    output logic       switch_evt,
    output logic       loopback_err
);
    import bus_1553_pkg::*;

    localparam int         c_idle_cyc  = CLOCK_SPEED / 1000000 * IDLE_US;
    localparam int         c_echo_dly  = 3 + LOOP_DELAY;
    localparam logic [7:0] c_echo_dly8 = 8'(c_echo_dly);
    localparam logic [7:0] c_mm_limit  = 8'(MISMATCH_LIMIT);

    logic [1:0] w_sync_a, w_sync_b, w_echo;
    logic       w_busy_a, w_busy_b, w_act_busy, w_oth_busy;
    logic       w_in_tx, w_mismatch;

    logic [1:0] r_state;
    logic       r_active, r_evt, r_err;
    logic [1:0] r_a_o, r_b_o;
    logic       r_a_en, r_b_en;
    logic [7:0] r_mm_cnt, r_fill, r_drain;
    logic [1:0] r_dly [c_echo_dly];

    activity_det_1553 #(.IDLE_CYC(c_idle_cyc)) u_act_a (
        .clk         (aclk),
        .rst         (arst),
        .i_diff      (bus_a_i_diff),
        .o_sync_diff (w_sync_a),
        .o_busy      (w_busy_a)
    );

    activity_det_1553 #(.IDLE_CYC(c_idle_cyc)) u_act_b (
        .clk         (aclk),
        .rst         (arst),
        .i_diff      (bus_b_i_diff),
        .o_sync_diff (w_sync_b),
        .o_busy      (w_busy_b)
    );

    assign w_act_busy  = (r_active == BUS_B) ? w_busy_b : w_busy_a;
    assign w_oth_busy  = (r_active == BUS_B) ? w_busy_a : w_busy_b;
    assign w_echo      = (r_active == BUS_B) ? w_sync_b : w_sync_a;
    assign core_i_diff = w_echo;

    assign bus_a_o_diff    = r_a_o;
    assign bus_a_en_o_diff = r_a_en;
    assign bus_b_o_diff    = r_b_o;
    assign bus_b_en_o_diff = r_b_en;
    assign active_bus      = r_active;
    assign bus_a_busy      = w_busy_a;
    assign bus_b_busy      = w_busy_b;
    assign switch_evt      = r_evt;
    assign loopback_err    = r_err;

    // Echo is compared only once the delay line holds data sent in this transmission.
    assign w_in_tx    = (r_state == ST_TX) || (r_state == ST_TX_TAIL);
    assign w_mismatch = w_in_tx && (r_fill == c_echo_dly8) && (w_echo != r_dly[c_echo_dly-1]);

    always_ff @(posedge aclk) begin
        if (arst) begin
            for (int k = 0; k < c_echo_dly; k++) r_dly[k] <= 2'b00;
        end else begin
            r_dly[0] <= core_o_diff;
            for (int k = 1; k < c_echo_dly; k++) r_dly[k] <= r_dly[k-1];
        end
    end

    always_ff @(posedge aclk) begin
        if (arst) begin
            r_state  <= ST_IDLE;
            r_active <= BUS_A;
            r_evt    <= 1'b0;
            r_err    <= 1'b0;
            r_a_o    <= 2'b00;
            r_a_en   <= 1'b0;
            r_b_o    <= 2'b00;
            r_b_en   <= 1'b0;
            r_mm_cnt <= 8'd0;
            r_fill   <= 8'd0;
            r_drain  <= 8'd0;
        end else begin
            // Selection only moves while the core is not transmitting, so the mux never splits a word.
            r_a_en <= core_en_o_diff && (r_active == BUS_A);
            r_a_o  <= (r_active == BUS_A) ? core_o_diff : 2'b00;
            r_b_en <= core_en_o_diff && (r_active == BUS_B);
            r_b_o  <= (r_active == BUS_B) ? core_o_diff : 2'b00;
            r_evt  <= 1'b0;

            if (w_mismatch && (r_mm_cnt != 8'hFF))
                r_mm_cnt <= r_mm_cnt + 8'd1;
            if (w_in_tx && (r_fill != c_echo_dly8))
                r_fill <= r_fill + 8'd1;

            if (w_mismatch && (r_mm_cnt >= c_mm_limit))
                r_err <= 1'b1;
            else if (err_clr)
                r_err <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (core_en_o_diff) begin
                        r_state  <= ST_TX;
                        r_mm_cnt <= 8'd0;
                        r_fill   <= 8'd0;
                    end else if (w_act_busy) begin
                        r_state <= ST_RX;
                    end else if (auto_switch && w_oth_busy) begin
                        r_active <= ~r_active;
                        r_evt    <= 1'b1;
                        r_state  <= ST_RX;
                    end else if (!auto_switch && (bus_sel != r_active)) begin
                        r_active <= ~r_active;
                        r_evt    <= 1'b1;
                    end
                end
                ST_TX: begin
                    if (!core_en_o_diff) begin
                        r_state <= ST_TX_TAIL;
                        r_drain <= c_echo_dly8;
                    end
                end
                ST_TX_TAIL: begin
                    if (core_en_o_diff)
                        r_state <= ST_TX;
                    else if (r_drain == 8'd0)
                        r_state <= ST_IDLE;
                    else
                        r_drain <= r_drain - 8'd1;
                end
                default: begin
                    if (core_en_o_diff) begin
                        r_state  <= ST_TX;
                        r_mm_cnt <= 8'd0;
                        r_fill   <= 8'd0;
                    end else if (!w_act_busy) begin
                        r_state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bus_ab_switch_1553.sv
`default_nettype none
// ============================================================================
// Module   : tb_bus_ab_switch_1553
// Purpose  : Directed self-checking bench for the 1553 bus A/B switch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bus_ab_switch_1553;
    import bus_1553_pkg::*;

    logic       clk = 1'b0;
    logic       arst;
    logic [1:0] core_o_diff;
    logic       core_en_o_diff;
    logic [1:0] core_i_diff;
    logic [1:0] bus_a_i_diff, bus_b_i_diff;
    logic [1:0] bus_a_o_diff, bus_b_o_diff;
    logic       bus_a_en_o_diff, bus_b_en_o_diff;
    logic       bus_sel, auto_switch, err_clr;
    logic       active_bus, bus_a_busy, bus_b_busy, switch_evt, loopback_err;

    logic       loop_a;
    logic [1:0] a_drv, b_drv;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Bus A transceiver model: either echoes its transmitter or is driven directly.
    assign bus_a_i_diff = loop_a ? bus_a_o_diff : a_drv;
    assign bus_b_i_diff = b_drv;

    bus_ab_switch_1553 dut (
        .aclk            (clk),
        .arst            (arst),
        .core_o_diff     (core_o_diff),
        .core_en_o_diff  (core_en_o_diff),
        .core_i_diff     (core_i_diff),
        .bus_a_i_diff    (bus_a_i_diff),
        .bus_a_o_diff    (bus_a_o_diff),
        .bus_a_en_o_diff (bus_a_en_o_diff),
        .bus_b_i_diff    (bus_b_i_diff),
        .bus_b_o_diff    (bus_b_o_diff),
        .bus_b_en_o_diff (bus_b_en_o_diff),
        .bus_sel         (bus_sel),
        .auto_switch     (auto_switch),
        .err_clr         (err_clr),
        .active_bus      (active_bus),
        .bus_a_busy      (bus_a_busy),
        .bus_b_busy      (bus_b_busy),
        .switch_evt      (switch_evt),
        .loopback_err    (loopback_err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arst = 1'b1; core_o_diff = 2'b00; core_en_o_diff = 1'b0;
        bus_sel = 1'b0; auto_switch = 1'b0; err_clr = 1'b0;
        loop_a = 1'b0; a_drv = 2'b00; b_drv = 2'b00;
        tick(); tick();
        arst = 1'b0;
    endtask

    task automatic test_reset();
        logic [12:0] obs;
        do_reset();
        tick();
        obs = {core_i_diff, bus_a_o_diff, bus_a_en_o_diff, bus_b_o_diff, bus_b_en_o_diff,
               active_bus, bus_a_busy, bus_b_busy, switch_evt, loopback_err};
        n_cmp++;
        if (obs !== 13'd0) begin
            n_err++; $display("FAIL reset_outputs: got %b expected %b", obs, 13'd0);
        end
        n_cmp++;
        if (dut.r_state !== ST_IDLE) begin
            n_err++; $display("FAIL reset_state: got %0d expected %0d", dut.r_state, ST_IDLE);
        end
    endtask

    task automatic test_tx_loop();
        logic [1:0] prev;
        do_reset();
        loop_a = 1'b1;
        core_en_o_diff = 1'b1; core_o_diff = 2'b01; prev = 2'b01;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_cmp++;
            if ({bus_a_en_o_diff, bus_a_o_diff, bus_b_en_o_diff, bus_b_o_diff} !== {1'b1, prev, 1'b0, 2'b00}) begin
                n_err++;
                $display("FAIL tx_a_route cyc %0d: got a_en=%b a_o=%b b_en=%b b_o=%b expected 1 %b 0 00",
                         i, bus_a_en_o_diff, bus_a_o_diff, bus_b_en_o_diff, bus_b_o_diff, prev);
            end
            prev = (i % 2 == 1) ? 2'b10 : 2'b01;
            core_o_diff = prev;
        end
        core_en_o_diff = 1'b0; core_o_diff = 2'b00;
        tick();
        n_cmp++;
        if (bus_a_en_o_diff !== 1'b0) begin
            n_err++; $display("FAIL tx_a_en_drop: got %b expected 0", bus_a_en_o_diff);
        end
        for (int i = 0; i < 10; i++) tick();
        n_cmp++;
        if (loopback_err !== 1'b0) begin
            n_err++; $display("FAIL tx_loop_clean: got %b expected 0", loopback_err);
        end
        n_cmp++;
        if (bus_a_busy !== 1'b1) begin
            n_err++; $display("FAIL tx_echo_busy: got %b expected 1", bus_a_busy);
        end
    endtask

    task automatic test_loop_err();
        do_reset();
        core_en_o_diff = 1'b1; core_o_diff = 2'b01;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 12) begin
                n_cmp++;
                if (loopback_err !== 1'b0) begin
                    n_err++; $display("FAIL err_before_9th: got %b expected 0", loopback_err);
                end
            end
            if (i == 13) begin
                n_cmp++;
                if (loopback_err !== 1'b1) begin
                    n_err++; $display("FAIL err_at_9th: got %b expected 1", loopback_err);
                end
            end
            core_o_diff = (i % 2 == 1) ? 2'b10 : 2'b01;
        end
        core_en_o_diff = 1'b0; core_o_diff = 2'b00;
        for (int i = 0; i < 10; i++) tick();
        n_cmp++;
        if ({loopback_err, dut.r_state} !== {1'b1, ST_IDLE}) begin
            n_err++; $display("FAIL err_sticky: got err=%b st=%0d expected err=1 st=%0d", loopback_err, dut.r_state, ST_IDLE);
        end
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_cmp++;
        if (loopback_err !== 1'b0) begin
            n_err++; $display("FAIL err_clear: got %b expected 0", loopback_err);
        end
        tick();
        n_cmp++;
        if (loopback_err !== 1'b0) begin
            n_err++; $display("FAIL err_stay_clear: got %b expected 0", loopback_err);
        end
    endtask

    task automatic test_auto_switch();
        int evts = 0;
        do_reset();
        auto_switch = 1'b1;
        b_drv = 2'b01;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (switch_evt === 1'b1) evts++;
            if (i == 1) b_drv = 2'b10;
            if (i == 2) b_drv = 2'b01;
            if (i == 3) b_drv = 2'b10;
        end
        n_cmp++;
        if (evts !== 1) begin
            n_err++; $display("FAIL auto_evt_count: got %0d expected 1", evts);
        end
        n_cmp++;
        if (active_bus !== 1'b1) begin
            n_err++; $display("FAIL auto_active: got %b expected 1", active_bus);
        end
        b_drv = 2'b11;
        tick();
        n_cmp++;
        if (core_i_diff !== 2'b10) begin
            n_err++; $display("FAIL rx_b_lat1: got %b expected 10", core_i_diff);
        end
        tick();
        n_cmp++;
        if (core_i_diff !== 2'b11) begin
            n_err++; $display("FAIL rx_b_lat2: got %b expected 11", core_i_diff);
        end
        for (int i = 0; i < 210; i++) tick();
        n_cmp++;
        if ({bus_b_busy, active_bus, dut.r_state} !== {1'b0, 1'b1, ST_IDLE}) begin
            n_err++;
            $display("FAIL auto_quiet: got busy=%b act=%b st=%0d expected busy=0 act=1 st=%0d",
                     bus_b_busy, active_bus, dut.r_state, ST_IDLE);
        end
    endtask

    task automatic test_tx_vs_rx();
        int evts = 0;
        int bad_b = 0;
        do_reset();
        auto_switch = 1'b1; loop_a = 1'b1;
        core_en_o_diff = 1'b1; core_o_diff = 2'b01; b_drv = 2'b01;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (switch_evt === 1'b1) evts++;
            if (bus_b_en_o_diff !== 1'b0) bad_b++;
            core_o_diff = (i % 2 == 1) ? 2'b10 : 2'b01;
            b_drv = (i % 2 == 1) ? 2'b10 : 2'b01;
        end
        n_cmp++;
        if ({evts, bad_b} !== {32'd0, 32'd0}) begin
            n_err++; $display("FAIL txrx_no_switch: got evts=%0d b_en_cycles=%0d expected 0 0", evts, bad_b);
        end
        n_cmp++;
        if ({active_bus, bus_a_en_o_diff, dut.r_state} !== {1'b0, 1'b1, ST_TX}) begin
            n_err++;
            $display("FAIL txrx_on_a: got act=%b a_en=%b st=%0d expected 0 1 %0d",
                     active_bus, bus_a_en_o_diff, dut.r_state, ST_TX);
        end
        core_en_o_diff = 1'b0;
    endtask

    task automatic test_sel_mid_tx();
        do_reset();
        core_en_o_diff = 1'b1; core_o_diff = 2'b01;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i == 3) bus_sel = 1'b1;
        end
        n_cmp++;
        if ({active_bus, switch_evt, bus_a_en_o_diff} !== 3'b001) begin
            n_err++; $display("FAIL sel_held_in_tx: got %b expected 001", {active_bus, switch_evt, bus_a_en_o_diff});
        end
        core_en_o_diff = 1'b0; core_o_diff = 2'b00;
        for (int i = 9; i <= 13; i++) begin
            tick();
            n_cmp++;
            if ({active_bus, switch_evt} !== 2'b00) begin
                n_err++; $display("FAIL sel_wait_drain cyc %0d: got %b expected 00", i, {active_bus, switch_evt});
            end
        end
        tick();
        n_cmp++;
        if ({active_bus, switch_evt} !== 2'b11) begin
            n_err++; $display("FAIL sel_switch: got %b expected 11", {active_bus, switch_evt});
        end
        tick();
        n_cmp++;
        if ({active_bus, switch_evt} !== 2'b10) begin
            n_err++; $display("FAIL sel_evt_pulse: got %b expected 10", {active_bus, switch_evt});
        end
        core_en_o_diff = 1'b1; core_o_diff = 2'b10;
        tick();
        n_cmp++;
        if ({bus_b_en_o_diff, bus_b_o_diff, bus_a_en_o_diff, bus_a_o_diff} !== 6'b110000) begin
            n_err++;
            $display("FAIL tx_on_b: got %b expected 110000", {bus_b_en_o_diff, bus_b_o_diff, bus_a_en_o_diff, bus_a_o_diff});
        end
        tick();
        arst = 1'b1;
        tick();
        n_cmp++;
        if ({bus_b_en_o_diff, bus_a_en_o_diff, active_bus} !== 3'b000) begin
            n_err++; $display("FAIL rst_mid_tx: got %b expected 000", {bus_b_en_o_diff, bus_a_en_o_diff, active_bus});
        end
        arst = 1'b0;
        core_en_o_diff = 1'b0;
    endtask

    initial begin
        test_reset();
        test_tx_loop();
        test_loop_err();
        test_auto_switch();
        test_tx_vs_rx();
        test_sel_mid_tx();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
